ram_bus_arbiter: RTL and testbench
==================================

Name: ram_bus_arbiter

Overview:
- Shares the single-port ram between two masters: cpu (port A) and dma (port B, the io-side transfer engine).
- Owner-based arbitration: one master owns the ram bus until it releases it or exhausts its burst budget.
- Registered grants, round-robin fairness between masters, optional dma burst lock.
- Sits between the cpu/dma request buses and the ram's addr/data/w_notr pins; all on the ram clock.

Parameters:
- SZ, 8, ram address width in bits.
- WSZ, 8, data word width in bits.
- MAX_BURST, 4, max consecutive accesses an owner may make while the other master waits (>=1).

Ports:
- clk  input  1  ram/cpu clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_req  input  1  cpu requests an access this cycle.
- a_addr  input  SZ  cpu address.
- a_w_notr  input  1  1=write, 0=read.
- a_wdata  input  WSZ  cpu write data.
- a_gnt  output  1  cpu owns the bus.
- a_ack  output  1  one-cycle pulse: a cpu access completed.
- a_rdata  output  WSZ  cpu read data, valid with a_ack on reads.
- b_req, b_addr, b_w_notr, b_wdata, b_gnt, b_ack, b_rdata: same as a_* for dma.
- b_lock  input  1  dma holds ownership across its burst budget.
- ram_addr  output  SZ  to ram.
- ram_wdata  output  WSZ  to ram.
- ram_w_notr  output  1  to ram; 1 only during a write access.
- ram_en  output  1  access strobe to ram.
- ram_rdata  input  WSZ  ram read data, valid one cycle after ram_en.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, rr_last=B (so cpu wins the first tie), burst_cnt=0. All outputs 0: gnt, ack, ram_en, ram_w_notr, ram_addr, ram_wdata, rdata.
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - Only one req high -> that master's OWN state next cycle.
  - Both high -> master != rr_last.
  - No access is issued in IDLE. Grant latency is 1 cycle from first sampled req.
- OWN_x:
  - x_gnt=1.
  - Each cycle x_req=1: ram_en=1 and ram_addr/ram_wdata/ram_w_notr = x's inputs (combinational mux from owner), burst_cnt++.
  - x_ack pulses 1 cycle after each access. x_rdata captures ram_rdata in that same cycle and holds until the next read ack.
  - Write acks leave x_rdata unchanged.
- Release:
  - Owner drops req -> ownership released at the next edge. No access is issued that cycle.
  - Budget exhausted: burst_cnt==MAX_BURST with other master requesting -> forced release after the MAX_BURST-th access.
  - Exception: B with b_lock=1 is never forced off.
  - On release: rr_last=owner, burst_cnt=0. Next state = other master's OWN if it is requesting (no IDLE bubble), else IDLE.
  - The ack of the last access still issues in the cycle after release.
- Other master idle: burst_cnt saturates at MAX_BURST and the owner keeps the bus indefinitely.
- Non-owner requests: never reach the ram. Non-owner ack=0. A master must hold req high (address stable) until its gnt arrives.
- gnt never high on both masters; ram_en never high without gnt.
- Reset mid-burst: all state cleared at that edge. A pending ack is dropped and no ram access issues in the reset cycle.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined:
  - cpu has fixed priority; rr_last is ignored.
  - IDLE ties go to A.
  - A forces B off after B's budget even with b_lock=1, if a_req is high.
  - A is never forced off.
- Undefined: round-robin and b_lock behaviour as above.

Decomposition:
- Shared package arb_pkg: state encoding (IDLE/OWN_A/OWN_B), owner id constants (OWN_ID_A=0, OWN_ID_B=1), default MAX_BURST.
- One natural sub-module, arb_burst_counter: saturating counter with clear, used for burst_cnt. Mux and FSM stay in the top.

Test Plan:
- Reset, then a_req=1 read at addr 0x10 (ram holds 0x5A) -> a_gnt rises 1 cycle later; ram_en with ram_addr=0x10 the same cycle; a_ack with a_rdata=0x5A the next cycle.
- a_req and b_req both rise together after reset -> A granted first. With MAX_BURST=4 and both held: 4 A accesses, then b_gnt directly with no idle cycle, then 4 B, then back to A.
- B writes 0xC3 to 0x20 with b_lock=1 for 6 accesses while a_req=1 -> 6 consecutive B accesses; a_gnt=0 throughout; A gets the bus after b_req drops.
- Same with ARB_FIXED_PRIO_EN defined -> B forced off after 4 accesses despite b_lock; a_gnt asserts the next cycle.
- rst asserted during B's 2nd access -> next cycle all gnt/ack/ram_en = 0, state IDLE; a subsequent b_req is granted after 1 cycle.
- Single master A holding req for 10 cycles, B idle -> 10 back-to-back accesses; gnt never drops; burst_cnt saturates at 4.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants for the cpu/dma ram bus arbiter: FSM encoding, owner ids,
// default burst budget and the burst counter width helper.
package arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  localparam logic OWN_ID_A = 1'b0;
  localparam logic OWN_ID_B = 1'b1;

  localparam int DEF_MAX_BURST = 4;

  // Wide enough to hold the saturated value MAX_BURST itself.
  function automatic int cnt_width(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating up-counter with synchronous clear; counts accesses made by the
// current bus owner. Clear wins over increment.
module arb_burst_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_bus_arbiter.sv
// Owner-based arbiter sharing one single-port ram between cpu (A) and dma (B).
// Optional build macro ARB_FIXED_PRIO_EN: cpu fixed priority, overrides b_lock.
//
// Handshake: a master raises x_req and holds it (address stable) until x_gnt;
// while x_gnt is high every cycle with x_req=1 is one ram access, acknowledged
// by a one-cycle x_ack in the following cycle (x_rdata valid with it on reads).
module ram_bus_arbiter
  import arb_pkg::*;
#(
  parameter int SZ        = 8,
  parameter int WSZ       = 8,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_req,
  input  logic [SZ-1:0]  a_addr,
  input  logic           a_w_notr,
  input  logic [WSZ-1:0] a_wdata,
  output logic           a_gnt,
  output logic           a_ack,
  output logic [WSZ-1:0] a_rdata,
  input  logic           b_req,
  input  logic [SZ-1:0]  b_addr,
  input  logic           b_w_notr,
  input  logic [WSZ-1:0] b_wdata,
  output logic           b_gnt,
  output logic           b_ack,
  output logic [WSZ-1:0] b_rdata,
  input  logic           b_lock,
  output logic [SZ-1:0]  ram_addr,
  output logic [WSZ-1:0] ram_wdata,
  output logic           ram_w_notr,
  output logic           ram_en,
  input  logic [WSZ-1:0] ram_rdata,
  output logic [1:0]     dbg_state_o
);

  localparam int CW = cnt_width(MAX_BURST);

  logic [1:0]     state_q, state_d;
  logic           rr_last_q, rr_last_d;
  logic           a_ack_q, b_ack_q;
  logic           a_rd_q, b_rd_q;
  logic [WSZ-1:0] a_rdata_q, b_rdata_q;
  logic [CW-1:0]  burst_cnt;
  logic           acc_a, acc_b;
  logic           release_own;
  logic           exhausted;
  logic           force_a, force_b;

  // No access may reach the ram in a reset cycle, even mid-burst.
  assign acc_a = !rst && (state_q == ST_OWN_A) && a_req;
  assign acc_b = !rst && (state_q == ST_OWN_B) && b_req;

  // Only consulted while the owner keeps requesting, so an access is implied.
  assign exhausted = (burst_cnt == CW'(MAX_BURST)) ||
                     (burst_cnt == CW'(MAX_BURST - 1));

`ifdef ARB_FIXED_PRIO_EN
  assign force_a = 1'b0;
  assign force_b = a_req && exhausted;
`else
  assign force_a = b_req && exhausted;
  assign force_b = a_req && exhausted && !b_lock;
`endif

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    release_own = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (a_req && b_req) begin
`ifdef ARB_FIXED_PRIO_EN
          state_d = ST_OWN_A;
`else
          state_d = (rr_last_q == OWN_ID_B) ? ST_OWN_A : ST_OWN_B;
`endif
        end else if (a_req) begin
          state_d = ST_OWN_A;
        end else if (b_req) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!a_req || force_a) begin
          release_own = 1'b1;
          rr_last_d   = OWN_ID_A;
          state_d     = b_req ? ST_OWN_B : ST_IDLE;
        end
      end
      ST_OWN_B: begin
        if (!b_req || force_b) begin
          release_own = 1'b1;
          rr_last_d   = OWN_ID_B;
          state_d     = a_req ? ST_OWN_A : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  arb_burst_counter #(
    .MAX (MAX_BURST),
    .W   (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (release_own),
    .inc_i (acc_a || acc_b),
    .cnt_o (burst_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= OWN_ID_B;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rd_q    <= 1'b0;
      b_rd_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      a_ack_q   <= acc_a;
      b_ack_q   <= acc_b;
      a_rd_q    <= acc_a && !a_w_notr;
      b_rd_q    <= acc_b && !b_w_notr;
      if (a_ack_q && a_rd_q) a_rdata_q <= ram_rdata;
      if (b_ack_q && b_rd_q) b_rdata_q <= ram_rdata;
    end
  end

  // Owner mux towards the ram; everything reads as zero when no access issues.
  always_comb begin
    ram_en     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_w_notr = 1'b0;
    if (acc_a) begin
      ram_en     = 1'b1;
      ram_addr   = a_addr;
      ram_wdata  = a_wdata;
      ram_w_notr = a_w_notr;
    end else if (acc_b) begin
      ram_en     = 1'b1;
      ram_addr   = b_addr;
      ram_wdata  = b_wdata;
      ram_w_notr = b_w_notr;
    end
  end

  assign a_gnt   = (state_q == ST_OWN_A);
  assign b_gnt   = (state_q == ST_OWN_B);
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  // Read data is passed straight through in the ack cycle, then held.
  assign a_rdata = (a_ack_q && a_rd_q) ? ram_rdata : a_rdata_q;
  assign b_rdata = (b_ack_q && b_rd_q) ? ram_rdata : b_rdata_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against an owner/budget reference model.
module tb_ram_bus_arbiter;
  import arb_pkg::*;

  localparam int SZ  = 8;
  localparam int WSZ = 8;
  localparam int MB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           a_req, a_w_notr, b_req, b_w_notr, b_lock;
  logic [SZ-1:0]  a_addr, b_addr;
  logic [WSZ-1:0] a_wdata, b_wdata;
  logic           a_gnt, a_ack, b_gnt, b_ack;
  logic [WSZ-1:0] a_rdata, b_rdata;
  logic [SZ-1:0]  ram_addr;
  logic [WSZ-1:0] ram_wdata;
  logic           ram_w_notr, ram_en;
  logic [WSZ-1:0] ram_rdata = '0;
  logic [1:0]     dbg_state;

  ram_bus_arbiter #(.SZ(SZ), .WSZ(WSZ), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_w_notr(a_w_notr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_w_notr(b_w_notr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata), .b_lock(b_lock),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_notr(ram_w_notr),
    .ram_en(ram_en), .ram_rdata(ram_rdata), .dbg_state_o(dbg_state)
  );

  function automatic logic [WSZ-1:0] init_val(input int i);
    if (i == 16) return 8'h5A;
    return WSZ'((i * 7 + 3) & 255);
  endfunction

  // Ram model: one-cycle read latency.
  logic           ram_init;
  logic [WSZ-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (ram_en) begin
      if (ram_w_notr) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner 0=none 1=cpu 2=dma, accesses made by the owner so far.
  int             m_own, m_last, m_cnt;
  logic           m_ack [2];
  logic           m_rd_pend [2];
  logic [WSZ-1:0] m_rd_data [2];
  logic [WSZ-1:0] m_hold [2];
  logic [WSZ-1:0] ref_mem [256];

  logic o_a_gnt, o_b_gnt, o_ram_en, o_a_ack, o_b_ack;
  logic [1:0] o_dbg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_cnt = 0;
    for (int x = 0; x < 2; x++) begin
      m_ack[x] = 1'b0; m_rd_pend[x] = 1'b0; m_rd_data[x] = '0; m_hold[x] = '0;
    end
  endtask

  task automatic check_outputs();
    logic acc_a, acc_b;
    logic [WSZ-1:0] exp_ra, exp_rb;
    acc_a = !rst && (m_own == 1) && a_req;
    acc_b = !rst && (m_own == 2) && b_req;
    chk("a_gnt", 32'(a_gnt), 32'(m_own == 1));
    chk("b_gnt", 32'(b_gnt), 32'(m_own == 2));
    chk("ram_en", 32'(ram_en), 32'(acc_a || acc_b));
    if (acc_a) begin
      chk("ram_addr_a", 32'(ram_addr), 32'(a_addr));
      chk("ram_w_notr_a", 32'(ram_w_notr), 32'(a_w_notr));
      if (a_w_notr) chk("ram_wdata_a", 32'(ram_wdata), 32'(a_wdata));
    end else if (acc_b) begin
      chk("ram_addr_b", 32'(ram_addr), 32'(b_addr));
      chk("ram_w_notr_b", 32'(ram_w_notr), 32'(b_w_notr));
      if (b_w_notr) chk("ram_wdata_b", 32'(ram_wdata), 32'(b_wdata));
    end else begin
      chk("ram_w_notr_idle", 32'(ram_w_notr), 32'(0));
    end
    exp_ra = (m_ack[0] && m_rd_pend[0]) ? m_rd_data[0] : m_hold[0];
    exp_rb = (m_ack[1] && m_rd_pend[1]) ? m_rd_data[1] : m_hold[1];
    chk("a_ack", 32'(a_ack), 32'(m_ack[0]));
    chk("b_ack", 32'(b_ack), 32'(m_ack[1]));
    chk("a_rdata", 32'(a_rdata), 32'(exp_ra));
    chk("b_rdata", 32'(b_rdata), 32'(exp_rb));
    o_a_gnt = a_gnt; o_b_gnt = b_gnt; o_ram_en = ram_en;
    o_a_ack = a_ack; o_b_ack = b_ack; o_dbg = dbg_state;
  endtask

  task automatic model_step();
    logic acc_a, acc_b, own_req, oth_req, forced;
    int other;
    if (rst) begin
      model_reset();
      return;
    end
    acc_a = (m_own == 1) && a_req;
    acc_b = (m_own == 2) && b_req;
    for (int x = 0; x < 2; x++) if (m_ack[x] && m_rd_pend[x]) m_hold[x] = m_rd_data[x];
    m_ack[0] = acc_a; m_rd_pend[0] = acc_a && !a_w_notr;
    m_ack[1] = acc_b; m_rd_pend[1] = acc_b && !b_w_notr;
    if (acc_a) begin
      if (a_w_notr) ref_mem[a_addr] = a_wdata; else m_rd_data[0] = ref_mem[a_addr];
    end
    if (acc_b) begin
      if (b_w_notr) ref_mem[b_addr] = b_wdata; else m_rd_data[1] = ref_mem[b_addr];
    end
    if (m_own == 0) begin
      if (a_req && b_req) begin
`ifdef ARB_FIXED_PRIO_EN
        m_own = 1;
`else
        m_own = (m_last == 2) ? 1 : 2;
`endif
      end else if (a_req) m_own = 1;
      else if (b_req) m_own = 2;
    end else begin
      own_req = (m_own == 1) ? a_req : b_req;
      oth_req = (m_own == 1) ? b_req : a_req;
      other   = (m_own == 1) ? 2 : 1;
      forced  = 1'b0;
      if (own_req) begin
        if (m_cnt < MB) m_cnt++;
        forced = oth_req && (m_cnt == MB);
`ifdef ARB_FIXED_PRIO_EN
        if (m_own == 1) forced = 1'b0;
`else
        if (m_own == 2 && b_lock) forced = 1'b0;
`endif
      end
      if (!own_req || forced) begin
        m_last = m_own;
        m_cnt  = 0;
        m_own  = oth_req ? other : 0;
      end
    end
  endtask

  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_req = 0; a_addr = '0; a_w_notr = 0; a_wdata = '0;
    b_req = 0; b_addr = '0; b_w_notr = 0; b_wdata = '0; b_lock = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drive_random();
    if (m_own == 1) begin
      if ($urandom_range(0, 3) == 0) a_req = 1'b0;
      else begin
        a_addr = SZ'($urandom_range(0, 255)); a_w_notr = 1'($urandom_range(0, 1));
        a_wdata = WSZ'($urandom_range(0, 255));
      end
    end else if (!a_req && $urandom_range(0, 2) == 0) begin
      a_req = 1'b1; a_addr = SZ'($urandom_range(0, 255));
      a_w_notr = 1'($urandom_range(0, 1)); a_wdata = WSZ'($urandom_range(0, 255));
    end
    if (m_own == 2) begin
      if ($urandom_range(0, 3) == 0) b_req = 1'b0;
      else begin
        b_addr = SZ'($urandom_range(0, 255)); b_w_notr = 1'($urandom_range(0, 1));
        b_wdata = WSZ'($urandom_range(0, 255));
      end
    end else if (!b_req && $urandom_range(0, 2) == 0) begin
      b_req = 1'b1; b_addr = SZ'($urandom_range(0, 255));
      b_w_notr = 1'($urandom_range(0, 1)); b_wdata = WSZ'($urandom_range(0, 255));
    end
    b_lock = 1'($urandom_range(0, 1));
    rst = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    int na, nb, first_b, drops;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    idle_inputs();
    ram_init = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    do_reset();

    // reset state
    cycle();
    chk("rst_a_gnt", 32'(o_a_gnt), 0);
    chk("rst_b_gnt", 32'(o_b_gnt), 0);
    chk("rst_ram_en", 32'(o_ram_en), 0);
    chk("rst_state", 32'(o_dbg), 32'(ST_IDLE));

    // single cpu read of 0x10
    a_req = 1; a_addr = 8'h10; a_w_notr = 0;
    cycle();
    chk("a_gnt_latency", 32'(o_a_gnt), 0);
    cycle();
    chk("a_first_access", 32'(o_ram_en && o_a_gnt), 1);
    a_req = 0;
    cycle();
    chk("a_ack_read", 32'(o_a_ack), 1);
    cycle();

    // both request together: round-robin bursts with no idle bubble
    do_reset();
    a_req = 1; a_addr = 8'h30; b_req = 1; b_addr = 8'h40;
    na = 0; first_b = -1; drops = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (o_b_gnt && first_b < 0) first_b = i;
      if (first_b < 0 && o_a_gnt && o_ram_en) na++;
      if (i > 0 && !o_a_gnt && !o_b_gnt) drops++;
    end
    chk("rr_a_burst", 32'(na), 4);
    chk("rr_first_b", 32'(first_b), 5);
    chk("rr_no_bubble", 32'(drops), 0);
    idle_inputs();
    cycle();

    // dma locked write burst while cpu waits
    do_reset();
    b_req = 1; b_lock = 1; b_w_notr = 1; b_addr = 8'h20; b_wdata = 8'hC3;
    cycle();
    a_req = 1; a_addr = 8'h20; a_w_notr = 0;
    na = 0; nb = 0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_b_gnt && o_ram_en) nb++;
    end
    chk("fixed_b_forced", 32'(nb), 4);
    b_req = 0;
    cycle();
    chk("fixed_a_owns", 32'(o_a_gnt), 1);
`else
    for (int i = 0; i < 20 && nb < 6; i++) begin
      cycle();
      if (o_b_gnt && o_ram_en) nb++;
      if (o_a_gnt) na++;
    end
    chk("lock_b_accesses", 32'(nb), 6);
    chk("lock_a_held_off", 32'(na), 0);
    b_req = 0;
    cycle();
    cycle();
    chk("a_gnt_after_b", 32'(o_a_gnt), 1);
`endif
    cycle();
    a_req = 0;
    cycle();
    cycle();

    // reset in the middle of a dma burst
    do_reset();
    b_req = 1; b_addr = 8'h05; b_w_notr = 0;
    cycle();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    chk("mid_rst_gnt", 32'(o_a_gnt || o_b_gnt), 0);
    chk("mid_rst_ack", 32'(o_a_ack || o_b_ack), 0);
    chk("mid_rst_en", 32'(o_ram_en), 0);
    chk("mid_rst_state", 32'(o_dbg), 32'(ST_IDLE));
    cycle();
    chk("b_gnt_after_rst", 32'(o_b_gnt), 1);
    b_req = 0;
    cycle();
    cycle();

    // lone cpu holds the bus for 10 back-to-back accesses
    do_reset();
    a_req = 1; a_addr = 8'h00;
    cycle();
    na = 0; drops = 0;
    for (int i = 0; i < 10; i++) begin
      a_addr = SZ'(i + 8'h50); a_w_notr = 1'($urandom_range(0, 1));
      a_wdata = WSZ'($urandom_range(0, 255));
      cycle();
      if (o_a_gnt && o_ram_en) na++;
      if (!o_a_gnt) drops++;
    end
    chk("solo_accesses", 32'(na), 10);
    chk("solo_gnt_drops", 32'(drops), 0);
    chk("solo_burst_sat", 32'(dut.u_cnt.cnt_o), 32'(MB));
    a_req = 0;
    cycle();
    cycle();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive_random();
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
